// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types for the memory port arbiter.
//   state_t : arbiter FSM states
//   owner_t : which requester owns the current access
//   word_t  : 32-bit memory word as 4 bytes, byte [0] is the most significant
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    typedef logic [0:3][7:0] word_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundle of requester and shared-memory signals.
//   fetch side : i_req, i_addr -> i_ack, i_rdata, i_stall
//   data side  : d_req, d_we, d_addr, d_wdata -> d_ack, d_rdata, d_stall
//   memory     : mem_addr, mem_data_in, mem_write_en <- mem_data_out
//   status     : busy
// slave modport is the arbiter's view, master is the environment's view.
interface mem_port_arbiter_if;
    import mem_arb_pkg::*;

    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    word_t       i_rdata;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    word_t       d_wdata;
    logic        d_ack;
    word_t       d_rdata;

    logic [31:0] mem_addr;
    word_t       mem_data_in;
    logic        mem_write_en;
    word_t       mem_data_out;

    logic        i_stall;
    logic        d_stall;
    logic        busy;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
        output i_ack, i_rdata, d_ack, d_rdata,
               mem_addr, mem_data_in, mem_write_en,
               i_stall, d_stall, busy
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_data_out,
        input  i_ack, i_rdata, d_ack, d_rdata,
               mem_addr, mem_data_in, mem_write_en,
               i_stall, d_stall, busy
    );

endinterface

// File: rtl/mem_port_arbiter_select.sv
// mem_arb_select: combinational winner selection.
//   i_req, d_req     : pending requests
//   starve_at_limit  : fetch has waited through the allowed number of data grants
//   owner            : winning requester
//   valid            : at least one request is pending
module mem_arb_select
    import mem_arb_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
    input  logic   starve_at_limit,
    output owner_t owner,
    output logic   valid
);

    always_comb begin
        valid = i_req | d_req;
        // Data has priority unless fetch is both waiting and starved.
        owner = (d_req && !(i_req && starve_at_limit)) ? OWN_D : OWN_I;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between a fetch
// requester and a data requester.
//   clk   : clock, rising edge
//   rst_b : asynchronous reset, active high
//   bus   : requester handshakes, shared memory port and status (slave view)
// Parameters: MEM_LATENCY (cycles per access, 1..15), STARVE_LIMIT
// (consecutive data grants allowed while fetch waits).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_LATENCY  = 4,
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic               clk,
    input  logic               rst_b,
    mem_port_arbiter_if.slave  bus
);

    state_t      state;
    state_t      state_nxt;
    owner_t      owner_q;
    owner_t      sel_owner;
    logic        sel_valid;
    logic [3:0]  lat_cnt;
    logic [7:0]  starve_cnt;
    logic [29:0] word_addr_q;
    logic        we_q;
    word_t       wdata_q;
    word_t       i_rdata_q;
    word_t       d_rdata_q;

    logic        grant;
    logic        last_access;
    logic        starve_at_limit;
    logic        i_ack;
    logic        d_ack;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    word_t       mem_data_in;

    assign starve_at_limit = (starve_cnt == 8'(STARVE_LIMIT));

    mem_arb_select u_select (
        .i_req           (bus.i_req),
        .d_req           (bus.d_req),
        .starve_at_limit (starve_at_limit),
        .owner           (sel_owner),
        .valid           (sel_valid)
    );

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        grant        = 1'b0;
        last_access  = 1'b0;
        i_ack        = 1'b0;
        d_ack        = 1'b0;
        mem_write_en = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '0;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    grant     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr = {word_addr_q, 2'b00};
                if (lat_cnt == 4'(MEM_LATENCY - 1)) begin
                    last_access = 1'b1;
                    state_nxt   = DONE;
                end
                if (last_access && we_q) begin
                    mem_write_en = 1'b1;
                    mem_data_in  = wdata_q;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                // A fetch whose request has gone away is silently dropped.
                i_ack = (owner_q == OWN_I) && bus.i_req;
                d_ack = (owner_q == OWN_D);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            owner_q     <= OWN_I;
            lat_cnt     <= '0;
            starve_cnt  <= '0;
            word_addr_q <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            if (grant) begin
                owner_q     <= sel_owner;
                word_addr_q <= (sel_owner == OWN_D) ? bus.d_addr[31:2] : bus.i_addr[31:2];
                we_q        <= (sel_owner == OWN_D) && bus.d_we;
                wdata_q     <= bus.d_wdata;
                lat_cnt     <= '0;
                // Count data grants that made a waiting fetch wait again.
                if (sel_owner == OWN_D && bus.i_req) begin
                    if (!starve_at_limit) starve_cnt <= starve_cnt + 8'd1;
                end else begin
                    starve_cnt <= '0;
                end
            end else if (state == ACCESS) begin
                lat_cnt <= lat_cnt + 4'd1;
            end
            if (last_access) begin
                if (owner_q == OWN_D) d_rdata_q <= we_q ? wdata_q : bus.mem_data_out;
                else                  i_rdata_q <= bus.mem_data_out;
            end
        end
    end

    assign bus.i_ack        = i_ack;
    assign bus.d_ack        = d_ack;
    assign bus.i_rdata      = i_rdata_q;
    assign bus.d_rdata      = d_rdata_q;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_data_in  = mem_data_in;
    assign bus.mem_write_en = mem_write_en;
    assign bus.i_stall      = bus.i_req & ~i_ack;
    assign bus.d_stall      = bus.d_req & ~d_ack;
    assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: self-checking bench for mem_port_arbiter.
// A word-array memory sits on the shared port; a transaction-level model
// predicts the winner, access window, write pulse and returned data.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int unsigned LAT = 4;
    localparam int unsigned LIM = 2;

    logic clk   = 1'b0;
    logic rst_b = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(LIM)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus.slave)
    );

    word_t mem     [0:255];
    word_t ref_mem [0:255];

    assign bus.mem_data_out = mem[bus.mem_addr[9:2]];

    function automatic word_t init_word(input int unsigned i);
        logic [7:0] b;
        b = 8'(i);
        return {b, ~b, b ^ 8'h5a, 8'h33};
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = init_word(i);
        forever begin
            @(posedge clk);
            if (bus.mem_write_en) mem[bus.mem_addr[9:2]] = bus.mem_data_in;
        end
    end

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int unsigned starve = 0;
    bit          at_done = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic req_i(input logic [31:0] a);
        bus.i_req  = 1'b1;
        bus.i_addr = a;
    endtask

    task automatic req_d(input bit w, input logic [31:0] a, input word_t wd);
        bus.d_req   = 1'b1;
        bus.d_we    = w;
        bus.d_addr  = a;
        bus.d_wdata = wd;
    endtask

    // Leaves the bench at the negedge of an IDLE cycle with nothing granted.
    task automatic go_idle();
        if (at_done) @(negedge clk);
        at_done = 1'b0;
    endtask

    // off = 1 when requests were raised in IDLE, 2 when raised during DONE.
    task automatic run_txn(input int unsigned off);
        bit          ip, dp, win_d, we;
        logic [31:0] a, ea;
        word_t       exp;
        ip    = bus.i_req;
        dp    = bus.d_req;
        win_d = dp && (!ip || starve < LIM);
        a     = win_d ? bus.d_addr : bus.i_addr;
        ea    = {a[31:2], 2'b00};
        we    = win_d && bus.d_we;
        exp   = we ? bus.d_wdata : ref_mem[a[9:2]];
        for (int unsigned k = 1; k <= off + LAT; k++) begin
            @(negedge clk);
            if (k < off) begin
                check("gap_busy", bus.busy, 0);
                check("gap_addr", bus.mem_addr, 0);
            end else if (k < off + LAT) begin
                check("acc_addr", bus.mem_addr, ea);
                check("acc_busy", bus.busy, 1);
                check("acc_we", bus.mem_write_en, we && (k == off + LAT - 1));
                if (we && (k == off + LAT - 1)) check("acc_wdata", bus.mem_data_in, exp);
                check("acc_iack", bus.i_ack, 0);
                check("acc_dack", bus.d_ack, 0);
                check("acc_istall", bus.i_stall, ip);
            end else begin
                check("done_we", bus.mem_write_en, 0);
                check("done_addr", bus.mem_addr, 0);
                check("done_iack", bus.i_ack, !win_d);
                check("done_dack", bus.d_ack, win_d);
                if (win_d) check("d_rdata", bus.d_rdata, exp);
                else       check("i_rdata", bus.i_rdata, exp);
                if (win_d) check("d_stall", bus.d_stall, 0);
                else       check("i_stall", bus.i_stall, 0);
            end
        end
        if (we) ref_mem[a[9:2]] = exp;
        if (win_d) begin
            starve    = ip ? ((starve < LIM) ? starve + 1 : LIM) : 0;
            bus.d_req = 1'b0;
        end else begin
            starve    = 0;
            bus.i_req = 1'b0;
        end
        at_done = 1'b1;
    endtask

    initial begin
        word_t wd;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        // reset state
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_iack", bus.i_ack, 0);
        check("rst_dack", bus.d_ack, 0);
        check("rst_we", bus.mem_write_en, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_irdata", bus.i_rdata, 0);
        check("rst_drdata", bus.d_rdata, 0);
        rst_b = 1'b0;

        // single fetch from idle, sub-word address
        req_i(32'h0000_0103);
        run_txn(1);

        // write then read back
        go_idle();
        req_d(1'b1, 32'h0000_0080, 32'hAABB_CCDD);
        run_txn(1);
        req_d(1'b0, 32'h0000_0080, '0);
        run_txn(2);
        check("rb80", bus.d_rdata, 32'hAABB_CCDD);

        // simultaneous requests with data held: D, D, I, D
        go_idle();
        req_i($urandom);
        req_d(1'b0, 32'h0000_0040, '0);
        run_txn(1);
        req_d(1'b0, 32'h0000_0040, '0);
        run_txn(2);
        req_d(1'b0, 32'h0000_0040, '0);
        run_txn(2);
        run_txn(2);

        // fetch cancelled mid-access
        go_idle();
        req_i(32'h0000_0204);
        repeat (2) @(negedge clk);
        bus.i_req = 1'b0;
        for (int unsigned k = 3; k <= LAT + 1; k++) begin
            @(negedge clk);
            check("cxl_iack", bus.i_ack, 0);
            check("cxl_busy", bus.busy, 1);
        end
        @(negedge clk);
        check("cxl_idle", bus.busy, 0);
        check("cxl_iack_idle", bus.i_ack, 0);
        check("cxl_rdata", bus.i_rdata, ref_mem[129]);
        starve = 0;

        // reset during the third ACCESS cycle of a write
        wd = $urandom;
        req_d(1'b1, 32'h0000_0300, wd);
        repeat (3) begin
            @(negedge clk);
            check("pre_rst_we", bus.mem_write_en, 0);
        end
        rst_b = 1'b1;
        #1;
        check("mid_rst_we", bus.mem_write_en, 0);
        check("mid_rst_dack", bus.d_ack, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_addr", bus.mem_addr, 0);
        check("mid_rst_irdata", bus.i_rdata, 0);
        check("mid_rst_drdata", bus.d_rdata, 0);
        @(negedge clk);
        check("mid_rst_we2", bus.mem_write_en, 0);
        rst_b  = 1'b0;
        starve = 0;
        run_txn(1);
        req_d(1'b0, 32'h0000_0300, '0);
        run_txn(2);

        // randomized traffic
        for (int it = 0; it < 300; it++) begin
            if (!bus.i_req && !bus.d_req && $urandom_range(0, 3) == 0) go_idle();
            if (!bus.i_req && $urandom_range(0, 2) != 0) req_i($urandom);
            if (!bus.d_req && $urandom_range(0, 2) != 0) req_d(1'($urandom_range(0, 1)), $urandom, $urandom);
            if (!bus.i_req && !bus.d_req) req_i($urandom);
            run_txn(at_done ? 2 : 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
